// File: rtl/rp_8bit_io_timer_if.sv
// I/O bus and interrupt lines between the core (master) and a timer (slave).
// io_* is the rp_8bit peripheral bus; irq_req/irq_ack are the two IRQ lines.
interface rp_8bit_io_timer_if;
  logic       io_wen;
  logic       io_ren;
  logic [5:0] io_adr;
  logic [7:0] io_wdt;
  logic [7:0] io_msk;
  logic [7:0] io_rdt;
  logic [1:0] irq_req;
  logic [1:0] irq_ack;

  modport master (
    output io_wen, io_ren, io_adr,
    output io_wdt, io_msk, irq_ack,
    input  io_rdt, irq_req
  );

  modport slave (
    input  io_wen, io_ren, io_adr,
    input  io_wdt, io_msk, irq_ack,
    output io_rdt, irq_req
  );
endinterface

// File: rtl/rp_8bit_io_timer.sv
// 8-bit timer/counter with prescaler, overflow and compare-match IRQs.
// Ports: clk, rst (async, active-low), bus (slave: I/O regs + irq_req/ack).
module rp_8bit_io_timer #(
  parameter logic [5:0]  BASE = 6'h20,
  parameter int unsigned PSW  = 10
) (
  input logic               clk,
  input logic               rst,
  rp_8bit_io_timer_if.slave bus
);

  logic [7:0]     tcr_q, tcr_d;
  logic [7:0]     tcnt_q, tcnt_d;
  logic [7:0]     ocr_q, ocr_d;
  logic [7:0]     rdt_q, rdt_d;
  logic           ovf_q, ovf_d;
  logic           cmf_q, cmf_d;
  logic [PSW-1:0] psc_q, psc_d;
  logic [PSW-1:0] psc_lim;

  logic [5:0] off;
  logic       hit;
  logic       wr_tcr, wr_tcnt, wr_ocr, wr_tifr;
  logic [7:0] tcr_wr, tcnt_wr, ocr_wr, tifr_w1;
  logic       run, tick, ps_chg;
  logic       ovf_set, cmf_set;
  logic       ovf_clr, cmf_clr;
  logic       match;

  function automatic logic [7:0] merge(
    input logic [7:0] old,
    input logic [7:0] wdt,
    input logic [7:0] msk
  );
    return (wdt & msk) | (old & ~msk);
  endfunction

  // Subtraction wraps addresses below BASE to >= 4, so one compare decodes.
  assign off     = bus.io_adr - BASE;
  assign hit     = (off < 6'd4);
  assign wr_tcr  = bus.io_wen && hit && (off[1:0] == 2'd0);
  assign wr_tcnt = bus.io_wen && hit && (off[1:0] == 2'd1);
  assign wr_ocr  = bus.io_wen && hit && (off[1:0] == 2'd2);
  assign wr_tifr = bus.io_wen && hit && (off[1:0] == 2'd3);

  assign tcr_wr  = merge(tcr_q, bus.io_wdt, bus.io_msk) & 8'h7F;
  assign tcnt_wr = merge(tcnt_q, bus.io_wdt, bus.io_msk);
  assign ocr_wr  = merge(ocr_q, bus.io_wdt, bus.io_msk);
  assign tifr_w1 = wr_tifr ? (bus.io_wdt & bus.io_msk) : 8'h00;

  always_comb begin
    psc_lim = '0;
    case (tcr_q[3:1])
      3'd0:    psc_lim = '0;
      3'd1:    psc_lim = PSW'(10'd7);
      3'd2:    psc_lim = PSW'(10'd63);
      3'd3:    psc_lim = PSW'(10'd255);
      default: psc_lim = PSW'(10'd1023);
    endcase
  end

  assign run    = tcr_q[0] && (tcr_q[3:1] <= 3'd4);
  assign tick   = run && (psc_q == psc_lim);
  assign ps_chg = wr_tcr && (tcr_wr[3:1] != tcr_q[3:1]);
  assign psc_d  = (!run || ps_chg || tick) ? '0 : psc_q + PSW'(1);
  assign match  = (tcnt_q == ocr_q);

  // A TCNT write suppresses the tick entirely, including its flags.
  always_comb begin
    tcnt_d  = tcnt_q;
    ovf_set = 1'b0;
    cmf_set = 1'b0;
    if (wr_tcnt) begin
      tcnt_d = tcnt_wr;
    end else if (tick) begin
      cmf_set = match;
      if (match && tcr_q[4]) begin
        tcnt_d = 8'h00;
      end else if (tcnt_q == 8'hFF) begin
        tcnt_d  = 8'h00;
        ovf_set = 1'b1;
      end else begin
        tcnt_d = tcnt_q + 8'd1;
      end
    end
  end

  // Set beats clear when both land in the same cycle.
  assign ovf_clr = bus.irq_ack[0] | tifr_w1[0];
  assign cmf_clr = bus.irq_ack[1] | tifr_w1[1];
  assign ovf_d   = ovf_set | (ovf_q & ~ovf_clr);
  assign cmf_d   = cmf_set | (cmf_q & ~cmf_clr);
  assign tcr_d   = wr_tcr ? tcr_wr : tcr_q;
  assign ocr_d   = wr_ocr ? ocr_wr : ocr_q;

  always_comb begin
    rdt_d = 8'h00;
    if (bus.io_ren && hit) begin
      case (off[1:0])
        2'd0:    rdt_d = tcr_q;
        2'd1:    rdt_d = tcnt_q;
        2'd2:    rdt_d = ocr_q;
        default: rdt_d = {6'b0, cmf_q, ovf_q};
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tcr_q  <= 8'h00;
      tcnt_q <= 8'h00;
      ocr_q  <= 8'h00;
      rdt_q  <= 8'h00;
      ovf_q  <= 1'b0;
      cmf_q  <= 1'b0;
      psc_q  <= '0;
    end else begin
      tcr_q  <= tcr_d;
      tcnt_q <= tcnt_d;
      ocr_q  <= ocr_d;
      rdt_q  <= rdt_d;
      ovf_q  <= ovf_d;
      cmf_q  <= cmf_d;
      psc_q  <= psc_d;
    end
  end

  assign bus.io_rdt  = rdt_q;
  assign bus.irq_req = {cmf_q & tcr_q[6], ovf_q & tcr_q[5]};

endmodule

// File: tb/tb_rp_8bit_io_timer.sv
// Directed bench for rp_8bit_io_timer: register access, counting, IRQs.
// Inputs change on the falling edge; outputs are sampled there too.
module tb_rp_8bit_io_timer;

  localparam logic [5:0] B = 6'h20;

  logic clk;
  logic rst;
  int   errs;
  int   checks;
  logic [7:0] v;

  rp_8bit_io_timer_if bus ();

  rp_8bit_io_timer #(
    .BASE (B),
    .PSW  (10)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string      tag,
    input logic [7:0] got,
    input logic [7:0] exp
  );
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  task automatic wr(
    input logic [1:0] o,
    input logic [7:0] d,
    input logic [7:0] m
  );
    @(negedge clk);
    bus.io_wen = 1'b1;
    bus.io_adr = B + {4'b0, o};
    bus.io_wdt = d;
    bus.io_msk = m;
    @(negedge clk);
    bus.io_wen = 1'b0;
    bus.io_wdt = 8'h00;
    bus.io_msk = 8'h00;
  endtask

  task automatic rd(
    input  logic [5:0] a,
    output logic [7:0] d
  );
    @(negedge clk);
    bus.io_ren = 1'b1;
    bus.io_adr = a;
    @(negedge clk);
    bus.io_ren = 1'b0;
    d = bus.io_rdt;
  endtask

  task automatic stop_clear(input logic [7:0] ocr);
    wr(2'd0, 8'h00, 8'hFF);
    wr(2'd1, 8'h00, 8'hFF);
    wr(2'd2, ocr, 8'hFF);
    wr(2'd3, 8'hFF, 8'hFF);
  endtask

  initial begin
    errs        = 0;
    checks      = 0;
    rst         = 1'b0;
    bus.io_wen  = 1'b0;
    bus.io_ren  = 1'b0;
    bus.io_adr  = 6'h00;
    bus.io_wdt  = 8'h00;
    bus.io_msk  = 8'h00;
    bus.irq_ack = 2'b00;
    repeat (3) @(negedge clk);
    chk("rst_rdt", bus.io_rdt, 8'h00);
    chk("rst_irq", {6'b0, bus.irq_req}, 8'h00);
    rst = 1'b1;

    // reset values
    rd(B,        v); chk("rst_tcr",  v, 8'h00);
    rd(B + 6'd1, v); chk("rst_tcnt", v, 8'h00);
    rd(B + 6'd2, v); chk("rst_ocr",  v, 8'h00);
    rd(B + 6'd3, v); chk("rst_tifr", v, 8'h00);
    rd(B + 6'd4, v); chk("rst_unmap", v, 8'h00);

    // masked bit set / clear; EN is on for 4 ticks, OCR=0 matches once
    wr(2'd0, 8'hFF, 8'h01);
    rd(B, v); chk("msk_set", v, 8'h01);
    wr(2'd0, 8'h00, 8'h01);
    rd(B,        v); chk("msk_clr",  v, 8'h00);
    rd(B + 6'd1, v); chk("msk_tcnt", v, 8'h04);
    rd(B + 6'd3, v); chk("msk_tifr", v, 8'h02);
    wr(2'd0, 8'hFF, 8'h61);
    rd(B, v); chk("msk_61", v, 8'h61);
    @(negedge clk);
    chk("idle_rdt", bus.io_rdt, 8'h00);
    rd(B + 6'd4, v); chk("unmap_hi", v, 8'h00);
    rd(6'h1F,    v); chk("unmap_lo", v, 8'h00);

    // free-run overflow at /1
    stop_clear(8'h80);
    wr(2'd1, 8'hFD, 8'hFF);
    wr(2'd0, 8'h21, 8'hFF);
    repeat (2) @(negedge clk);
    rd(B + 6'd1, v); chk("ovf_tcnt", v, 8'h00);
    chk("ovf_irq", {6'b0, bus.irq_req}, 8'h01);
    rd(B + 6'd3, v); chk("ovf_tifr", v, 8'h01);
    @(negedge clk);
    bus.irq_ack = 2'b01;
    @(negedge clk);
    bus.irq_ack = 2'b00;
    chk("ack_irq", {6'b0, bus.irq_req}, 8'h00);

    // CTC at /8 with OCR=4: value after edge n is (n/8)%5
    stop_clear(8'h04);
    wr(2'd0, 8'h53, 8'hFF);
    for (int j = 0; j < 22; j++) begin
      rd(B + 6'd1, v);
      chk("ctc_tcnt", v, 8'(((2 * j + 1) / 8) % 5));
    end
    chk("ctc_irq", {6'b0, bus.irq_req}, 8'h02);
    rd(B + 6'd3, v); chk("ctc_tifr", v, 8'h02);

    // TIFR clear in the cycle CMF sets: set wins
    stop_clear(8'h04);
    wr(2'd0, 8'h11, 8'hFF);
    repeat (3) @(negedge clk);
    wr(2'd3, 8'h02, 8'hFF);
    rd(B + 6'd3, v); chk("col_tifr", v, 8'h02);
    wr(2'd0, 8'h00, 8'hFF);
    wr(2'd3, 8'h02, 8'hFF);
    rd(B + 6'd3, v); chk("w1c_tifr", v, 8'h00);

    // TCNT write on a /8 tick edge wins, next tick increments it
    stop_clear(8'h80);
    wr(2'd0, 8'h03, 8'hFF);
    repeat (6) @(negedge clk);
    wr(2'd1, 8'h10, 8'hFF);
    rd(B + 6'd1, v); chk("col_tcnt", v, 8'h10);
    repeat (6) @(negedge clk);
    rd(B + 6'd1, v); chk("col_next", v, 8'h11);

    // mid-run reset at /1024 with OVF pending
    wr(2'd0, 8'h00, 8'hFF);
    wr(2'd1, 8'hFF, 8'hFF);
    wr(2'd0, 8'h21, 8'hFF);
    wr(2'd0, 8'h29, 8'hFF);
    chk("pre_rst_irq", {6'b0, bus.irq_req}, 8'h01);
    repeat (5) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("in_rst_irq", {6'b0, bus.irq_req}, 8'h00);
    @(negedge clk);
    rst = 1'b1;
    rd(B,        v); chk("mr_tcr",  v, 8'h00);
    rd(B + 6'd1, v); chk("mr_tcnt", v, 8'h00);
    rd(B + 6'd2, v); chk("mr_ocr",  v, 8'h00);
    rd(B + 6'd3, v); chk("mr_tifr", v, 8'h00);
    chk("mr_irq", {6'b0, bus.irq_req}, 8'h00);
    repeat (2100) @(negedge clk);
    rd(B + 6'd1, v); chk("mr_idle", v, 8'h00);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
